// File: rtl/time_set_pkg.sv
// Shared types and defaults for the time-of-day set-mode controller.
//   state_t        : set-mode FSM states (IDLE, SET_MIN, SET_HOUR)
//   SYNC_STAGES    : flip-flops in each key synchroniser
//   DEF_*          : default parameter values used by time_set_ctrl / key_debounce
// The auto-repeat defaults exist only when TIME_SET_AUTO_REPEAT_EN is defined.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  localparam logic [19:0] DEF_DEBOUNCE_CYCLES = 20'd1_000_000;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES  = 32'd1_000_000_000;
  localparam logic [31:0] DEF_BLINK_CYCLES    = 32'd25_000_000;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam logic [31:0] DEF_REPEAT_DELAY    = 32'd50_000_000;
  localparam logic [31:0] DEF_REPEAT_PERIOD   = 32'd10_000_000;
`endif

endpackage

// File: rtl/key_debounce.sv
// One push-button input path: synchroniser -> debouncer -> rising-edge press.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous, active-high reset
//   key_raw in  raw, asynchronous, active-high button
//   level   out debounced key level
//   press   out registered one-cycle pulse on a debounced 0->1 transition
// A raw edge reaches 'press' after SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
module key_debounce
  import time_set_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [19:0]            r_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_press;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign level    = r_level;
  assign press    = r_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw};
      // The synced value must disagree with the level for DEBOUNCE_CYCLES
      // consecutive cycles; any agreement restarts the count.
      if (w_synced != r_level) begin
        if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
          r_level <= w_synced;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Set-mode sequencer for the time-of-day timer.
// Two raw buttons are debounced (key_debounce x2); a set press walks
// IDLE -> SET_MIN -> SET_HOUR -> IDLE, an increase press in SET_* issues a
// one-cycle inc_minute / inc_hour pulse. Set mode auto-exits after
// TIMEOUT_CYCLES without a press, and blink_phase flashes the edited field.
// Ports:
//   clk, reset (async, active-high), power_state (0 forces IDLE),
//   set_key, increase_key (raw buttons),
//   set_mode, set_select (0=minute, 1=hour), inc_minute, inc_hour, blink_phase.
// Build option: define TIME_SET_AUTO_REPEAT_EN to add auto-repeat of a held
// increase key (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [31:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] BLINK_CYCLES    = DEF_BLINK_CYCLES
`ifdef TIME_SET_AUTO_REPEAT_EN
  ,
  parameter logic [31:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [31:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic power_state,
  input  logic set_key,
  input  logic increase_key,
  output logic set_mode,
  output logic set_select,
  output logic inc_minute,
  output logic inc_hour,
  output logic blink_phase
);

  logic w_set_press, w_set_level, w_inc_press, w_inc_level;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_key (
    .clk(clk), .reset(reset), .key_raw(set_key),
    .level(w_set_level), .press(w_set_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
    .clk(clk), .reset(reset), .key_raw(increase_key),
    .level(w_inc_level), .press(w_inc_press)
  );

  state_t      r_state, w_state_nxt;
  logic        r_inc_minute, r_inc_hour, w_inc_minute_nxt, w_inc_hour_nxt;
  logic [31:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic [31:0] r_blink_cnt, w_blink_cnt_nxt;
  logic        r_blink_phase, w_blink_phase_nxt;
  logic        w_tmo_hit, w_inc_fire, w_enter, w_rep_fire;

  assign set_mode    = (r_state != IDLE);
  assign set_select  = (r_state == SET_HOUR);
  assign inc_minute  = r_inc_minute;
  assign inc_hour    = r_inc_hour;
  assign blink_phase = r_blink_phase;

  assign w_tmo_hit = (r_state != IDLE) && (r_tmo_cnt == TIMEOUT_CYCLES - 32'd1);
  assign w_enter   = (w_state_nxt != IDLE) && (w_state_nxt != r_state);

  // Next state and increment request; branches are in priority order, so a
  // set press always beats a simultaneous increase press.
  always_comb begin
    w_state_nxt = r_state;
    w_inc_fire  = 1'b0;
    if (!power_state) begin
      w_state_nxt = IDLE;
    end else if (w_set_press) begin
      case (r_state)
        IDLE:    w_state_nxt = SET_MIN;
        SET_MIN: w_state_nxt = SET_HOUR;
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = IDLE;
    end else if ((r_state != IDLE) && (w_inc_press || w_rep_fire)) begin
      w_inc_fire = 1'b1;
    end
    w_inc_minute_nxt = w_inc_fire && (r_state == SET_MIN);
    w_inc_hour_nxt   = w_inc_fire && (r_state == SET_HOUR);
  end

  // Inactivity and blink timers.
  always_comb begin
    w_tmo_cnt_nxt     = r_tmo_cnt + 32'd1;
    w_blink_cnt_nxt   = r_blink_cnt + 32'd1;
    w_blink_phase_nxt = r_blink_phase;
    if (w_state_nxt == IDLE) begin
      w_tmo_cnt_nxt     = '0;
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
    end else begin
      if (w_enter || w_set_press || w_inc_press || w_inc_fire) begin
        w_tmo_cnt_nxt = '0;
      end
      if (w_enter || w_set_press) begin
        w_blink_cnt_nxt   = '0;
        w_blink_phase_nxt = 1'b0;
      end else if (r_blink_cnt == BLINK_CYCLES - 32'd1) begin
        w_blink_cnt_nxt   = '0;
        w_blink_phase_nxt = ~r_blink_phase;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_inc_minute  <= 1'b0;
      r_inc_hour    <= 1'b0;
      r_tmo_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_inc_minute  <= w_inc_minute_nxt;
      r_inc_hour    <= w_inc_hour_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  // r_rep_armed: an accepted press is being tracked while the key stays held.
  // r_rep_on: the initial delay has elapsed; r_rep_cnt now counts periods.
  logic        r_rep_armed, w_rep_armed_nxt;
  logic        r_rep_on, w_rep_on_nxt;
  logic [31:0] r_rep_cnt, w_rep_cnt_nxt;
  logic        w_unused_levels;

  assign w_unused_levels = w_set_level;
  assign w_rep_fire = r_rep_armed && w_inc_level &&
                      (r_rep_on ? (r_rep_cnt == REPEAT_PERIOD - 32'd1)
                                : (r_rep_cnt == REPEAT_DELAY - 32'd1));

  always_comb begin
    w_rep_armed_nxt = r_rep_armed;
    w_rep_on_nxt    = r_rep_on;
    w_rep_cnt_nxt   = r_rep_cnt + 32'd1;
    if ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) begin
      w_rep_armed_nxt = 1'b0;
      w_rep_on_nxt    = 1'b0;
      w_rep_cnt_nxt   = '0;
    end else if (w_inc_press) begin
      w_rep_armed_nxt = 1'b1;
      w_rep_on_nxt    = 1'b0;
      w_rep_cnt_nxt   = '0;
    end else if (!r_rep_armed || !w_inc_level) begin
      w_rep_armed_nxt = 1'b0;
      w_rep_on_nxt    = 1'b0;
      w_rep_cnt_nxt   = '0;
    end else if (w_rep_fire) begin
      w_rep_on_nxt  = 1'b1;
      w_rep_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_armed <= 1'b0;
      r_rep_on    <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_rep_armed <= w_rep_armed_nxt;
      r_rep_on    <= w_rep_on_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
    end
  end
`else
  logic w_unused_levels;
  assign w_unused_levels = w_set_level ^ w_inc_level;
  assign w_rep_fire      = 1'b0;
`endif

endmodule
